// File: rtl/multiplicador_segmentado_pkg.sv
// Shared definitions for the pipelined add-shift multiplier.
// Holds the default operand width, the payload carried between pipeline
// stages, and the two's-complement magnitude helper used by stage 0.
package multiplicador_segmentado_pkg;

  localparam int TAMANYO = 32;

  // Payload travelling down the pipeline. Magnitudes are unsigned; the sign
  // bits are only used at the output stage to correct the product sign.
  typedef struct packed {
    logic [2*TAMANYO-1:0] acc;     // partial product accumulator
    logic [TAMANYO-1:0]   mcand;   // |Den|
    logic [TAMANYO-1:0]   mplier;  // |Coc|
    logic [TAMANYO-1:0]   res;     // Res, kept signed
    logic                 sgn_coc;
    logic                 sgn_den;
    logic                 vld;
  } stage_t;

  // The most negative value maps to unsigned 2^(TAMANYO-1), which still fits
  // in TAMANYO unsigned bits, so no precision is lost.
  function automatic logic [TAMANYO-1:0] magnitud(input logic [TAMANYO-1:0] x);
    return x[TAMANYO-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/multiplicador_segmentado_aux_multiplicador.sv
// aux_multiplicador: one registered add-shift stage of the multiplier.
// Ports: CLK, RSTa (sync, active-high), i_stg payload in, o_stg payload out.
// Stage K adds (|Den| << (K-1)) to the accumulator when bit K-1 of |Coc| is set.
module aux_multiplicador
  import multiplicador_segmentado_pkg::*;
#(
  parameter int K = 1
) (
  input  logic   CLK,
  input  logic   RSTa,
  input  stage_t i_stg,
  output stage_t o_stg
);

  stage_t               r_stg;
  logic [2*TAMANYO-1:0] w_sumando;

  always_comb begin
    w_sumando = {{TAMANYO{1'b0}}, i_stg.mcand} << (K - 1);
  end

  // Only the valid bit needs clearing; data fields are don't-care while invalid.
  always_ff @(posedge CLK) begin
    if (RSTa) begin
      r_stg.vld <= 1'b0;
    end else begin
      r_stg <= i_stg;
      if (i_stg.mplier[K-1]) begin
        r_stg.acc <= i_stg.acc + w_sumando;
      end
    end
  end

  assign o_stg = r_stg;

endmodule

// File: rtl/multiplicador_segmentado.sv
// Pipelined signed multiply-add: Num = Coc*Den + Res, truncated to tamanyo bits.
// Ports: CLK, RSTa (sync, active-high), Start/Coc/Den/Res in; Done pulse + Num out,
// Ovf out only when MULT_OVERFLOW_EN is defined. Latency tamanyo+2, one op/cycle, no backpressure.
module multiplicador_segmentado
  import multiplicador_segmentado_pkg::*;
#(
  parameter int tamanyo = TAMANYO  // must match TAMANYO: the stage payload is sized by it
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               Start,
  input  logic [tamanyo-1:0] Coc,
  input  logic [tamanyo-1:0] Den,
  input  logic [tamanyo-1:0] Res,
  output logic               Done,
  output logic [tamanyo-1:0] Num
`ifdef MULT_OVERFLOW_EN
  ,
  output logic               Ovf
`endif
);

  stage_t r_stg0;
  stage_t w_stg [0:tamanyo];

  // Stage 0: capture magnitudes and signs; accumulator starts empty.
  always_ff @(posedge CLK) begin
    if (RSTa) begin
      r_stg0.vld <= 1'b0;
    end else begin
      r_stg0.acc     <= '0;
      r_stg0.mcand   <= magnitud(Den);
      r_stg0.mplier  <= magnitud(Coc);
      r_stg0.res     <= Res;
      r_stg0.sgn_coc <= Coc[tamanyo-1];
      r_stg0.sgn_den <= Den[tamanyo-1];
      r_stg0.vld     <= Start;
    end
  end

  assign w_stg[0] = r_stg0;

  for (genvar k = 1; k <= tamanyo; k++) begin : g_etapa
    aux_multiplicador #(.K(k)) u_etapa (
      .CLK   (CLK),
      .RSTa  (RSTa),
      .i_stg (w_stg[k-1]),
      .o_stg (w_stg[k])
    );
  end

  // Output stage: restore the product sign, then add sign-extended Res.
  logic [2*tamanyo-1:0] w_prod;
  logic [tamanyo-1:0]   w_num;

  always_comb begin
    w_prod = (w_stg[tamanyo].sgn_coc ^ w_stg[tamanyo].sgn_den) ?
             -w_stg[tamanyo].acc : w_stg[tamanyo].acc;
  end

`ifdef MULT_OVERFLOW_EN
  // |product| <= 2^(2*tamanyo-2), so one extra bit holds the exact sum.
  logic [2*tamanyo:0] w_full;
  logic               w_ovf;

  always_comb begin
    w_full = {w_prod[2*tamanyo-1], w_prod}
           + {{(tamanyo+1){w_stg[tamanyo].res[tamanyo-1]}}, w_stg[tamanyo].res};
    w_num  = w_full[tamanyo-1:0];
    // Representable only if every bit from the result sign upward agrees.
    w_ovf  = !((&w_full[2*tamanyo:tamanyo-1]) || !(|w_full[2*tamanyo:tamanyo-1]));
  end
`else
  always_comb begin
    w_num = w_prod[tamanyo-1:0] + w_stg[tamanyo].res;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RSTa) begin
      Done <= 1'b0;
      Num  <= '0;
`ifdef MULT_OVERFLOW_EN
      Ovf  <= 1'b0;
`endif
    end else begin
      Done <= w_stg[tamanyo].vld;
      if (w_stg[tamanyo].vld) begin
        Num <= w_num;
`ifdef MULT_OVERFLOW_EN
        Ovf <= w_ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_multiplicador_segmentado.sv
module tb_multiplicador_segmentado;

  localparam int W   = 32;
  localparam int LAT = W + 2;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W - 1));

  logic         CLK = 1'b0;
  logic         RSTa;
  logic         Start;
  logic [W-1:0] Coc, Den, Res;
  logic         Done;
  logic [W-1:0] Num;
`ifdef MULT_OVERFLOW_EN
  logic         Ovf;
`endif

  always #5 CLK = ~CLK;

  multiplicador_segmentado #(.tamanyo(W)) dut (
    .CLK   (CLK),
    .RSTa  (RSTa),
    .Start (Start),
    .Coc   (Coc),
    .Den   (Den),
    .Res   (Res),
    .Done  (Done),
    .Num   (Num)
`ifdef MULT_OVERFLOW_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  typedef struct {
    int           due;
    logic [W-1:0] num;
    logic         ovf;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_num = '0;
  logic         exp_ovf = 1'b0;
  int           last_done_cyc = -1;
  int           start_cyc;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] c, input logic [W-1:0] d,
                                 input logic [W-1:0] r, input int due);
    longint p;
    exp_t   e;
    p = longint'($signed(c)) * longint'($signed(d)) + longint'($signed(r));
    e.due = due;
    e.num = p[W-1:0];
    e.ovf = (p > MAXV) || (p < MINV);
    return e;
  endfunction

  // One clock cycle: drive inputs, let the edge pass, check outputs at negedge.
  task automatic tick(input bit st, input logic [W-1:0] c, input logic [W-1:0] d,
                      input logic [W-1:0] r, input bit rst);
    bit exp_done;
    Start = st; Coc = c; Den = d; Res = r; RSTa = rst;
    if (rst) begin
      q.delete();
      exp_num = '0;
      exp_ovf = 1'b0;
    end else if (st) begin
      q.push_back(model(c, d, r, cyc + LAT));
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    exp_done = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_done = 1'b1;
      exp_num  = q[0].num;
      exp_ovf  = q[0].ovf;
      void'(q.pop_front());
    end
    if (Done === 1'b1) last_done_cyc = cyc;
    chk("done", W'(Done), W'(exp_done));
    chk("num", Num, exp_num);
`ifdef MULT_OVERFLOW_EN
    chk("ovf", W'(Ovf), W'(exp_ovf));
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 4 * LAT) begin
      idle(1);
      guard++;
    end
    chk("drain_timeout", W'(q.size()), W'(0));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return '0;
      2:       return '1;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    Start = 1'b0; Coc = '0; Den = '0; Res = '0; RSTa = 1'b1;

    // Reset state
    tick(1'b0, '0, '0, '0, 1'b1);
    tick(1'b0, '0, '0, '0, 1'b1);

    // Basic product and exact latency
    start_cyc = cyc;
    tick(1'b1, 32'd7, 32'd3, 32'd2, 1'b0);
    drain();
    chk("latency", W'(last_done_cyc - start_cyc), 32'd34);
    chk("num_7x3p2", Num, 32'd23);

    // Sign combinations
    tick(1'b1, -32'sd7, 32'd3, -32'sd2, 1'b0);
    tick(1'b1, 32'd7, -32'sd3, 32'd2, 1'b0);
    drain();
    chk("num_7xm3p2", Num, 32'hFFFF_FFED);

    // Back-to-back throughput
    for (int i = 1; i <= 5; i++) tick(1'b1, W'(i), 32'd10, 32'd0, 1'b0);
    drain();
    chk("num_burst_last", Num, 32'd50);
    idle(3);

    // Boundary operands
    tick(1'b1, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
    drain();
    chk("num_minneg", Num, 32'h8000_0000);
    tick(1'b1, 32'd0, -32'sd5, 32'd9, 1'b0);
    drain();
    chk("num_zero_coc", Num, 32'd9);
    tick(1'b1, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0);
    tick(1'b1, '1, '1, '1, 1'b0);
    tick(1'b0, '0, '0, '0, 1'b0);
    tick(1'b1, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0);
    tick(1'b1, 32'd7, 32'd3, 32'd2, 1'b0);
    drain();

    // Reset mid-flight discards the operation; Start during reset is ignored
    tick(1'b1, 32'd123, 32'd456, 32'd7, 1'b0);
    idle(9);
    tick(1'b1, 32'd5, 32'd5, 32'd5, 1'b1);
    idle(LAT + 6);
    chk("num_after_reset", Num, 32'd0);
    start_cyc = cyc;
    tick(1'b1, 32'd11, -32'sd12, 32'd13, 1'b0);
    drain();
    chk("latency_after_reset", W'(last_done_cyc - start_cyc), 32'd34);

    // Randomized traffic with bubbles
    repeat (300) tick(($urandom_range(0, 3) != 0), pick(), pick(), pick(), 1'b0);
    drain();
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplicador_segmentado.md
MULTIPLICADOR_SEGMENTADO -- requirements
Module: multiplicador_segmentado

Interface
REQ-001 Parameter tamanyo, default 32, operand/result width in bits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RSTa  input  1  reset, synchronous, active-high.
REQ-004 Start  input  1  high: operands valid this cycle, accept one operation.
REQ-005 Coc  input  tamanyo  signed two's-complement quotient operand.
REQ-006 Den  input  tamanyo  signed two's-complement denominator operand.
REQ-007 Res  input  tamanyo  signed two's-complement remainder addend.
REQ-008 Done  output  1  one-cycle pulse per accepted operation; Num valid this cycle.
REQ-009 Num  output  tamanyo  reconstructed numerator Coc*Den+Res, low tamanyo bits.
REQ-010 Ovf  output  1  present only with MULT_OVERFLOW_EN; result not representable in tamanyo signed bits.

Function
REQ-011 Block SHALL compute Num = Coc*Den + Res in two's complement, truncated to tamanyo bits.
REQ-012 Stage 0 SHALL register |Coc|, |Den|, Res, sign bits and a valid bit; accumulator SHALL start at 0.
REQ-013 Stage k (k=1..tamanyo) SHALL add (|Den| << (k-1)) to a 2*tamanyo-bit accumulator when bit k-1 of |Coc| is 1, else pass it unchanged.
REQ-014 Output stage SHALL negate the accumulator when sign(Coc) XOR sign(Den), add sign-extended Res, and register Num and Done.
REQ-015 Latency SHALL be exactly tamanyo+2 cycles from the edge sampling Start=1 to the cycle Done=1.
REQ-016 Throughput SHALL be one operation per cycle; Start high on consecutive cycles SHALL yield Done on consecutive cycles, in order.
REQ-017 Start low SHALL insert a bubble; Done SHALL stay low for the corresponding cycle.
REQ-018 Num SHALL update only in Done cycles and hold its value otherwise.
REQ-019 Magnitude of most-negative input (1 followed by zeros) SHALL be treated as unsigned 2^(tamanyo-1) with no loss.
REQ-020 Zero operands SHALL yield product 0 with no sign correction artefacts (Num = Res).
REQ-021 There SHALL be no backpressure; Done is a pulse, not a held handshake.

Reset
REQ-022 While RSTa=1 at a rising edge: all valid bits, Done, Num and (if present) Ovf SHALL become 0.
REQ-023 Start sampled during a reset edge SHALL be ignored.
REQ-024 Reset mid-operation SHALL discard all in-flight operations; no Done SHALL be produced for them.
REQ-025 First Start after RSTa returns low SHALL be accepted and complete with normal latency.

Configuration
REQ-026 Macro MULT_OVERFLOW_EN defined: Ovf port exists; Ovf registered with Num, 1 when the full-precision signed Coc*Den+Res falls outside [-2^(tamanyo-1), 2^(tamanyo-1)-1].
REQ-027 Macro MULT_OVERFLOW_EN undefined: no Ovf port, no overflow logic; Num behaviour identical.

Structure
REQ-028 Shared package SHALL hold the default width constant and a typedef for the per-stage payload (accumulator, multiplicand, multiplier, Res, sign bits, valid).
REQ-029 One sub-module aux_multiplicador SHALL implement a single add-shift stage, instantiated tamanyo times via generate.
REQ-030 Output stage and stage 0 SHALL live in the top module.

Verification
REQ-031 Coc=7, Den=3, Res=2, single Start -> Done exactly 34 cycles later (tamanyo=32), Num=23.
REQ-032 Coc=-7, Den=3, Res=-2 -> Num=0xFFFFFFE9 (-23); Coc=7, Den=-3, Res=2 -> Num=0xFFFFFFED (-19).
REQ-033 Start held high 5 cycles with Coc=1..5, Den=10, Res=0 -> 5 consecutive Done pulses, Num=10,20,30,40,50; then Done low.
REQ-034 Coc=0x80000000, Den=1, Res=0 -> Num=0x80000000; Coc=0, Den=-5, Res=9 -> Num=9.
REQ-035 Start at cycle 0, RSTa=1 at cycle 10 for one cycle -> no Done ever for that operation; Num=0; new Start afterwards completes normally.
REQ-036 With MULT_OVERFLOW_EN: Coc=0x10000, Den=0x10000, Res=0 -> Num=0, Ovf=1; Coc=7, Den=3, Res=2 -> Ovf=0.
